muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, beside the ALU.
- Takes the same decoded operand pair as the ALU and produces a 32-bit result for the writeback select.
- Multi-cycle, with a start/busy/done handshake; the pipeline stalls on busy.
- Sequential shift-add multiply and restoring divide, one bit per cycle.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CALC_CYCLES, 32, iteration count; must equal XLEN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when idle.
- op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- data1  in  32 (uint32)  rs1 operand; captured on accept.
- data2  in  32 (uint32)  rs2 operand; captured on accept.
- flush  in  1  kill the in-flight operation.
- busy  out  1  operation in progress; stall request.
- done  out  1  one-cycle result-valid pulse.
- result  out  32 (uint32)  result; held until the next accept.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, result=0.
  - All internal accumulators, counters and sign flags cleared.
  - Reset mid-operation aborts with no done.
- States:
  - IDLE: busy=0. start=1 and flush=0 -> accept. Latch op, operands, sign flags and |operands|, counter=0.
    - Special divide case -> DONE.
    - Otherwise -> CALC.
  - CALC: busy=1. One iteration per cycle, counter++. After the iteration with counter=CALC_CYCLES-1 -> FIX.
  - FIX: busy=1. Apply sign correction, select high/low word, register result -> DONE.
  - DONE: busy=0, done=1 for exactly one cycle -> IDLE.
    - start=1 in DONE is accepted as if in IDLE, so back-to-back operations work.
- Latency, with start accepted at cycle 0:
  - normal op: done=1 in cycle 34.
  - special divide case: done=1 in cycle 1.
- start while state is CALC or FIX is ignored. Issuer must hold start until accepted; it is accepted only in IDLE or DONE.
- Operand signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: data1 signed, data2 unsigned.
  - MULHU, DIVU, REMU, MUL: unsigned magnitude. MUL low word is sign-independent.
- Multiply:
  - 64-bit product of magnitudes, one shift-add per cycle.
  - FIX negates the 64-bit value if the signs differ (per the signedness above).
  - MUL returns bits [31:0]; MULH, MULHSU, MULHU return bits [63:32].
- Divide:
  - Restoring divide on magnitudes, producing quotient and remainder.
  - Quotient negated if the signs differ (signed ops).
  - Remainder takes the sign of the dividend.
- Special divide cases (fast path, no CALC):
  - data2=0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> data1.
  - Signed DIV/REM with data1=0x80000000, data2=0xFFFFFFFF: DIV -> 0x80000000, REM -> 0.
- flush=1, synchronous:
  - Any state -> IDLE next cycle; done is not asserted and result is unchanged.
  - flush and start in the same cycle: flush wins, start is dropped.
  - flush in DONE: done still shows this cycle, then IDLE.
- Operand inputs may change freely after accept. Internal copies are used.
- result changes only on the edge entering DONE.

Test Plan:
- Reset: rst_n low mid-CALC -> busy=0, done=0, result=0 immediately. No done for 40 cycles after release with start=0.
- MUL/MULH: MUL 7 × 6 -> 42, done at cycle 34. MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000000. MULHU same operands -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- Signed divide: DIV −7 / 2 -> 0xFFFFFFFD (−3). REM −7 / 2 -> 0xFFFFFFFF (−1). DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- Special cases, each with done at cycle 1:
  - DIV 5 / 0 -> 0xFFFFFFFF.
  - REMU 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- Handshake:
  - start during CALC is ignored.
  - start in the DONE cycle begins the second op; its done comes 34 cycles later.
  - Operands changed after accept do not alter the result.
- Flush:
  - flush at cycle 10 of DIV -> IDLE, no done, previous result retained.
  - flush together with start -> no op accepted.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Start/busy/done handshake; divide-by-zero and signed overflow complete on a fast path.
//
// state  | meaning
// IDLE   | waiting for start; accepts a new operation
// CALC   | one multiply or divide iteration per cycle
// FIX    | sign correction and word select, result registered
// DONE   | done pulse for one cycle; may accept the next operation

module muldiv_unit #(
    parameter int XLEN        = 32,
    parameter int CALC_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(CALC_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [2:0]      r_op;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_dvs;
    logic [XLEN-1:0] r_result;
    logic            r_sign1;
    logic            r_sign2;
    logic [CW-1:0]   r_cnt;

    logic            w_accept;
    logic            w_is_div;
    logic            w_signed1;
    logic            w_signed2;
    logic            w_neg1;
    logic            w_neg2;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_last;

    assign w_accept  = ((r_state == S_IDLE) || (r_state == S_DONE)) && start && !flush;
    assign w_is_div  = op[2];
    assign w_signed1 = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    assign w_signed2 = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    assign w_neg1    = w_signed1 && data1[XLEN-1];
    assign w_neg2    = w_signed2 && data2[XLEN-1];
    assign w_mag1    = w_neg1 ? (~data1 + 1'b1) : data1;
    assign w_mag2    = w_neg2 ? (~data2 + 1'b1) : data2;

    // op[0]=0 marks the signed divide ops (DIV, REM); op[1]=1 marks the remainder ops
    assign w_div_zero = w_is_div && (data2 == '0);
    assign w_div_ovf  = w_is_div && !op[0] && (data1 == {1'b1, {(XLEN-1){1'b0}}}) && (data2 == '1);
    assign w_special  = w_div_zero || w_div_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero)
            w_special_res = op[1] ? data1 : '1;
        else
            w_special_res = op[1] ? '0 : data1;
    end

    assign w_last = (r_cnt == CW'(CALC_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_next = w_special ? S_DONE : S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                if (w_last)
                    w_next = S_FIX;
            end
            S_FIX: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (w_accept)
                    w_next = w_special ? S_DONE : S_CALC;
                else
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (flush)
            w_next = S_IDLE;
    end

    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_rem_sh;
    logic              w_ge;
    logic [XLEN-1:0]   w_rem_sub;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_res;

    // Multiply keeps {hi,lo} as partial product with the multiplier shifting out of lo.
    // Divide keeps the partial remainder in hi and shifts the quotient into lo.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_dvs} : '0);
    assign w_rem_sh  = {r_hi, r_lo[XLEN-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
    assign w_rem_sub = w_rem_sh[XLEN-1:0] - r_dvs;

    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = (r_sign1 ^ r_sign2) ? (~w_prod + 1'b1) : w_prod;
    assign w_quo    = (r_sign1 ^ r_sign2) ? (~r_lo + 1'b1) : r_lo;
    assign w_rem    = r_sign1 ? (~r_hi + 1'b1) : r_hi;

    always_comb begin
        w_fix_res = '0;
        if (r_op[2])
            w_fix_res = r_op[1] ? w_rem : w_quo;
        else if (r_op == 3'd0)
            w_fix_res = w_prod_s[XLEN-1:0];
        else
            w_fix_res = w_prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_dvs    <= '0;
            r_result <= '0;
            r_sign1  <= 1'b0;
            r_sign2  <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_op    <= op;
            r_sign1 <= w_neg1;
            r_sign2 <= w_neg2;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= w_is_div ? w_mag1 : w_mag2;
            r_dvs   <= w_is_div ? w_mag2 : w_mag1;
            if (w_special)
                r_result <= w_special_res;
        end else if (r_state == S_CALC && !flush) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_op[2]) begin
                r_hi <= w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0];
                r_lo <= {r_lo[XLEN-2:0], w_ge};
            end else begin
                r_hi <= w_mul_sum[XLEN:1];
                r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
            end
        end else if (r_state == S_FIX && !flush) begin
            r_result <= w_fix_res;
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table plus random ops checked through a result scoreboard,
// and hand-written sequences for reset, flush and handshake corner cases.

module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    muldiv_unit #(.XLEN(32), .CALC_CYCLES(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .data1  (data1),
        .data2  (data2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        int          lat;
        int          t0;
    } sb_t;

    vec_t        vecs[$];
    sb_t         sb_q[$];
    logic [31:0] last_exp = 32'h0;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        int          ia;
        int          ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        ia = $signed(a);
        ib = $signed(b);
        p  = '0;
        case (o)
            MUL:    begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            MULH:   begin p = sa * sb; return p[63:32]; end
            MULHSU: begin p = sa * ub; return p[63:32]; end
            MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            DIV: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            DIVU: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            REM: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && (b == 32'h0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 34;
    endfunction

    // Scoreboard consumer: every done pops one expected result and its latency.
    always @(negedge clk) begin
        sb_t e;
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: result=%h, expected no done", result);
            end else begin
                e = sb_q.pop_front();
                check("result", result, e.exp);
                check("latency", 32'(cyc - e.t0 + 1), 32'(e.lat));
                last_exp = e.exp;
            end
        end
    end

    // Called at a negedge while the unit is idle or in DONE; accepted at the next edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int lat);
        op    = o;
        data1 = a;
        data2 = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        sb_q.push_back('{exp: e, lat: lat, t0: cyc});
        start = 1'b0;
        op    = 3'($urandom);
        data1 = $urandom;
        data2 = $urandom;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic quiet(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          n;

        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        data1 = 32'h0;
        data2 = 32'h0;

        vecs.push_back('{MUL,    32'd7,         32'd6,         32'd42,        34});
        vecs.push_back('{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34});
        vecs.push_back('{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
        vecs.push_back('{MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34});
        vecs.push_back('{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34});
        vecs.push_back('{DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34});
        vecs.push_back('{REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34});
        vecs.push_back('{DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34});
        vecs.push_back('{REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         34});
        vecs.push_back('{DIVU,   32'd100,       32'd7,         32'd14,        34});
        vecs.push_back('{REMU,   32'd100,       32'd7,         32'd2,         34});
        vecs.push_back('{DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34});
        vecs.push_back('{DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{REMU,   32'd5,         32'd0,         32'd5,         1});
        vecs.push_back('{REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1});
        vecs.push_back('{DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});

        quiet(3);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
            wait_drain();
        end

        for (int i = 0; i < 16; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = (i % 4 == 1) ? 32'h8000_0000 : $urandom;
            rb = (i % 5 == 0) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom);
            @(negedge clk);
            issue(ro, ra, rb, ref_res(ro, ra, rb), ref_lat(ro, ra, rb));
            wait_drain();
        end

        // Back-to-back: second op issued in the DONE cycle of the first.
        @(negedge clk);
        issue(MUL, 32'd1234, 32'd5678, 32'd7006652, 34);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        issue(DIVU, 32'd1000, 32'd3, 32'd333, 34);
        wait_drain();

        // Special case followed immediately by another op from DONE.
        @(negedge clk);
        issue(REMU, 32'd9, 32'd0, 32'd9, 1);
        @(negedge clk);
        issue(REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34);
        wait_drain();

        // start held during CALC must not launch a second op.
        @(negedge clk);
        issue(MULHU, 32'hDEAD_BEEF, 32'h1234_5678, ref_res(MULHU, 32'hDEAD_BEEF, 32'h1234_5678), 34);
        quiet(3);
        check("busy_in_calc", 32'(busy), 32'd1);
        op    = DIV;
        data1 = 32'd50;
        data2 = 32'd0;
        start = 1'b1;
        quiet(20);
        start = 1'b0;
        wait_drain();
        quiet(40);

        // Flush in cycle 10 of a DIV: back to idle, no done, result kept.
        @(negedge clk);
        issue(DIV, 32'd1000, 32'd7, 32'd142, 34);
        quiet(9);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        void'(sb_q.pop_back());
        @(negedge clk);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_result", result, last_exp);
        quiet(40);
        check("flush_result_late", result, last_exp);

        // Flush together with start: nothing accepted.
        op    = MUL;
        data1 = 32'd3;
        data2 = 32'd3;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush_start_busy", 32'(busy), 32'd0);
        quiet(40);
        check("flush_start_result", result, last_exp);

        // Async reset mid-CALC clears outputs immediately; no done afterwards.
        @(negedge clk);
        issue(MUL, 32'd11, 32'd13, 32'd143, 34);
        quiet(5);
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'h0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        quiet(40);
        check("rst_result_after", result, 32'h0);

        // Still functional after reset.
        @(negedge clk);
        issue(MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
